// File: rtl/updown_counter_bcd_pkg.sv
// Shared types and elaboration helpers for the up/down BCD counter slice.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_e;

  // Decimal digits needed to show max_val (never less than one digit).
  function automatic int unsigned min_digits(input longint unsigned max_val);
    longint unsigned v;
    int unsigned     d;
    v = max_val;
    d = 1;
    for (int unsigned i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        d = d + 1;
      end
    end
    return d;
  endfunction

  function automatic int unsigned shift_cnt_width(input int unsigned width);
    return $clog2(width + 32'd1);
  endfunction

endpackage

// File: rtl/updown_counter_bcd_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: shift-add-3, one binary bit per enabled clock.
module bin2bcd_seq
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid,
  output logic                  busy
);

  localparam int unsigned CW = shift_cnt_width(WIDTH);

  conv_state_e             state, state_nx;
  logic [WIDTH-1:0]        bin_sr, bin_sr_nx;
  logic [4*DIGITS-1:0]     scratch, scratch_nx, scratch_adj;
  logic [4*DIGITS-1:0]     bcd_nx;
  logic [CW-1:0]           bit_cnt, bit_cnt_nx;
  logic                    valid_nx, busy_nx;

  function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] s);
    logic [4*DIGITS-1:0] r;
    r = s;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign scratch_adj = add3(scratch);

  always_comb begin
    state_nx   = state;
    bin_sr_nx  = bin_sr;
    scratch_nx = scratch;
    bit_cnt_nx = bit_cnt;
    bcd_nx     = bcd;
    valid_nx   = 1'b0;
    busy_nx    = busy;
    case (state)
      IDLE: begin
        if (ena && start) begin
          state_nx   = SHIFT;
          bin_sr_nx  = bin;
          scratch_nx = '0;
          bit_cnt_nx = '0;
          busy_nx    = 1'b1;
        end
      end
      SHIFT: begin
        if (ena) begin
          // Adjust digits first, then shift the binary MSB into the scratch LSB.
          {scratch_nx, bin_sr_nx} = {scratch_adj, bin_sr} << 1;
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == CW'(WIDTH - 1)) state_nx = DONE;
        end
      end
      DONE: begin
        if (ena) begin
          bcd_nx   = scratch;
          valid_nx = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bin_sr  <= '0;
      scratch <= '0;
      bit_cnt <= '0;
      bcd     <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      bin_sr  <= bin_sr_nx;
      scratch <= scratch_nx;
      bit_cnt <= bit_cnt_nx;
      bcd     <= bcd_nx;
      valid   <= valid_nx;
      busy    <= busy_nx;
    end
  end

endmodule

// File: rtl/updown_counter_bcd.sv
// Up/down modulo counter with load, terminal-count pulse and BCD display image.
// Define UPDOWN_COUNTER_SAT_EN for saturating limits instead of modulo wrap.
module updown_counter_bcd
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODULUS = 256,
  parameter int unsigned DIGITS  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic                 hold,
  output logic [WIDTH-1:0]     count,
  output logic                 tc,
  output logic [4*DIGITS-1:0]  bcd_out,
  output logic                 bcd_valid,
  output logic                 bcd_busy
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

  if ((MODULUS < 2) || (64'(MODULUS) > (64'd1 << WIDTH))) begin : g_modulus_chk
    $error("updown_counter_bcd: MODULUS out of range for WIDTH");
  end
  if (DIGITS < min_digits(64'(MODULUS - 1))) begin : g_digits_chk
    $error("updown_counter_bcd: DIGITS too small for MODULUS-1");
  end

  logic [WIDTH-1:0] count_nx;
  logic             tc_nx;
  logic             dirty, dirty_nx;
  logic             start;

  always_comb begin
    count_nx = count;
    tc_nx    = 1'b0;
    if (ena) begin
      if (load) begin
        count_nx = (load_val > CNT_MAX) ? CNT_MAX : load_val;
      end else if (inc && !dec) begin
        if (count == CNT_MAX) begin
`ifdef UPDOWN_COUNTER_SAT_EN
          count_nx = count;
`else
          count_nx = '0;
`endif
          tc_nx = 1'b1;
        end else begin
          count_nx = count + 1'b1;
        end
      end else if (dec && !inc) begin
        if (count == '0) begin
`ifdef UPDOWN_COUNTER_SAT_EN
          count_nx = count;
`else
          count_nx = CNT_MAX;
`endif
          tc_nx = 1'b1;
        end else begin
          count_nx = count - 1'b1;
        end
      end
    end
  end

  // Converter is idle exactly when busy is low, so busy gates new captures.
  assign start = ena && !hold && dirty && !bcd_busy;

  // A change on the capture edge must win: the converter sampled the old value.
  always_comb begin
    dirty_nx = dirty;
    if (count_nx != count) dirty_nx = 1'b1;
    else if (start)        dirty_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tc    <= 1'b0;
      dirty <= 1'b1;
    end else begin
      count <= count_nx;
      tc    <= tc_nx;
      dirty <= dirty_nx;
    end
  end

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .bin   (count),
    .bcd   (bcd_out),
    .valid (bcd_valid),
    .busy  (bcd_busy)
  );

endmodule
